// File: rtl/hdmi_pll_ctrl.sv
// rPLL dynamic-select sequencer: reset pulse, synced/filtered LOCK, timeout retries, mode switching.
// Optional saturating lock-loss counter is enabled by defining HDMI_PLL_CTRL_LOSS_CNT_EN.
module hdmi_pll_ctrl #(
  parameter int                      NUM_MODES     = 2,
  parameter int                      MODE_W        = 1,
  parameter logic [NUM_MODES*18-1:0] MODE_TABLE    = '0,
  parameter int                      RESET_CYCLES  = 16,
  parameter int                      LOCK_TIMEOUT  = 27000,
  parameter int                      STABLE_CYCLES = 1024,
  parameter int                      MAX_RETRIES   = 3
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [MODE_W-1:0] req_mode,
  output logic              req_ready,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [5:0]        pll_idsel,
  output logic [5:0]        pll_fbdsel,
  output logic [5:0]        pll_odsel,
  output logic [MODE_W-1:0] mode,
  output logic              ready,
  output logic              error
`ifdef HDMI_PLL_CTRL_LOSS_CNT_EN
  ,
  output logic [7:0]        lock_loss_cnt
`endif
);
  localparam int RC_W  = $clog2(RESET_CYCLES) + 1;
  localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int ST_W  = $clog2(STABLE_CYCLES) + 1;
  localparam int RT_W  = $clog2(MAX_RETRIES) + 1;
  // One counter serves RST/WAIT/STABLE; it is cleared on every state entry.
  localparam int CNT_W = (RC_W > TO_W) ? ((RC_W > ST_W) ? RC_W : ST_W)
                                       : ((TO_W > ST_W) ? TO_W : ST_W);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRIES);

  typedef enum logic [2:0] {S_RST, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RT_W-1:0]   retry_q, retry_d, retry_inc;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [17:0]       sel_q, sel_d;
  logic [1:0]        sync_q, sync_d;
  logic              pll_reset_q, pll_reset_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              req_ready_q, req_ready_d;
  logic              lock_s, accept, good;
`ifdef HDMI_PLL_CTRL_LOSS_CNT_EN
  logic [7:0]        loss_q, loss_d;
`endif

  function automatic logic [17:0] entry(input logic [MODE_W-1:0] m);
    return MODE_TABLE[int'(m)*18 +: 18];
  endfunction

  assign lock_s = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    mode_d    = mode_q;
    sel_d     = sel_q;
    sync_d    = {sync_q[0], pll_lock};
    retry_inc = retry_q + RT_W'(1);
    accept    = req_valid && req_ready_q;
    good      = accept && (32'(req_mode) < 32'(NUM_MODES));
    case (state_q)
      S_RST:
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      S_WAIT:
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = (retry_inc == RT_MAX) ? S_FAIL : S_RST;
        end else cnt_d = cnt_q + CNT_W'(1);
      S_STABLE:
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == ST_LAST) state_d = S_RUN;
        else cnt_d = cnt_q + CNT_W'(1);
      S_RUN:
        if (!lock_s) begin
          state_d = S_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      S_FAIL: ;
      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase
    // An accepted valid request overrides whatever the state logic chose.
    if (good) begin
      state_d = S_RST;
      cnt_d   = '0;
      retry_d = '0;
      mode_d  = req_mode;
      sel_d   = entry(req_mode);
    end
    pll_reset_d = (state_d == S_RST) || (state_d == S_FAIL);
    ready_d     = (state_d == S_RUN);
    error_d     = (state_d == S_FAIL);
    req_ready_d = (state_d == S_RUN) || (state_d == S_FAIL);
`ifdef HDMI_PLL_CTRL_LOSS_CNT_EN
    loss_d = loss_q;
    if ((state_q == S_RUN) && !lock_s && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
`endif
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      mode_q      <= '0;
      sel_q       <= MODE_TABLE[17:0];
      sync_q      <= '0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      req_ready_q <= 1'b0;
`ifdef HDMI_PLL_CTRL_LOSS_CNT_EN
      loss_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      sync_q      <= sync_d;
      pll_reset_q <= pll_reset_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      req_ready_q <= req_ready_d;
`ifdef HDMI_PLL_CTRL_LOSS_CNT_EN
      loss_q      <= loss_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign pll_reset  = pll_reset_q;
  assign pll_idsel  = sel_q[17:12];
  assign pll_fbdsel = sel_q[11:6];
  assign pll_odsel  = sel_q[5:0];
  assign mode       = mode_q;
  assign ready      = ready_q;
  assign error      = error_q;
`ifdef HDMI_PLL_CTRL_LOSS_CNT_EN
  assign lock_loss_cnt = loss_q;
`endif
endmodule
